// File: rtl/wall_scroller_pkg.sv
// Shared constants, FSM states and gap-top clamp for the wall scroller,
// its renderer and the height generator.
package wall_scroller_pkg;

    localparam int unsigned SCREEN_W_D = 160;
    localparam int unsigned WALL_W_D   = 8;
    localparam int unsigned GAP_D      = 32;
    localparam int unsigned MIN_TOP_D  = 8;
    localparam int unsigned MAX_TOP_D  = 80;
    localparam int unsigned BIRD_X_D   = 20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_SPAWN  = 2'd2
    } state_e;

    // Only the low seven bits of the random height matter; the sum is 8-bit.
    function automatic logic [6:0] clamp_top(input logic [7:0] h,
                                             input int unsigned min_top,
                                             input int unsigned max_top);
        logic [7:0] sum;
        sum = 8'(min_top) + (h & 8'h7F);
        if (sum > 8'(max_top)) sum = 8'(max_top);
        return sum[6:0];
    endfunction

endpackage

// File: rtl/wall_scroller_if.sv
// Bus between the wall scroller and its game controller / renderer.
interface wall_scroller_if #(
    parameter int unsigned NUM_WALLS = 4
) ();
    localparam int unsigned IDX_W = (NUM_WALLS > 1) ? $clog2(NUM_WALLS) : 1;

    logic             enable;
    logic             frame_tick;
    logic [7:0]       height_in;
    logic             height_ack;
    logic [6:0]       bird_y;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [7:0]       rd_x;
    logic [6:0]       rd_top;
    logic             busy;
    logic             frame_done;
    logic [7:0]       score;
    logic             collide;

    modport slave (
        input  enable, frame_tick, height_in, bird_y, rd_idx,
        output height_ack, rd_valid, rd_x, rd_top, busy, frame_done, score, collide
    );

    modport master (
        output enable, frame_tick, height_in, bird_y, rd_idx,
        input  height_ack, rd_valid, rd_x, rd_top, busy, frame_done, score, collide
    );
endinterface

// File: rtl/wall_scroller_slot_update.sv
// Combinational one-frame update of a single wall slot: scroll/retire,
// bird-pass detection and bird/wall collision against the new position.
module wall_slot_update #(
    parameter int unsigned SPEED  = 1,
    parameter int unsigned WALL_W = 8,
    parameter int unsigned GAP    = 32,
    parameter int unsigned BIRD_X = 20
) (
    input  logic       valid_i,
    input  logic [7:0] x_i,
    input  logic [6:0] top_i,
    input  logic [6:0] bird_y_i,
    output logic       valid_o,
    output logic [7:0] x_o,
    output logic       passed_o,
    output logic       hit_o
);
    logic       retire;
    logic [8:0] right_edge;
    logic [7:0] gap_end;

    always_comb begin
        retire     = valid_i && (x_i < 8'(SPEED));
        valid_o    = valid_i && !retire;
        x_o        = valid_o ? (x_i - 8'(SPEED)) : x_i;
        passed_o   = valid_o && (x_i >= 8'(BIRD_X)) && (x_o < 8'(BIRD_X));
        right_edge = {1'b0, x_o} + 9'(WALL_W);
        gap_end    = {1'b0, top_i} + 8'(GAP);
        hit_o      = valid_o && (x_o <= 8'(BIRD_X)) && (9'(BIRD_X) < right_edge) &&
                     ((bird_y_i < top_i) || ({1'b0, bird_y_i} >= gap_end));
    end
endmodule

// File: rtl/wall_scroller.sv
// Per-frame wall manager: scrolls one slot per cycle, then spawns at most
// one new wall; tracks score and a sticky collision flag.
module wall_scroller
    import wall_scroller_pkg::*;
#(
    parameter int unsigned NUM_WALLS = 4,
    parameter int unsigned SCREEN_W  = SCREEN_W_D,
    parameter int unsigned SPEED     = 1,
    parameter int unsigned SPACING   = 40,
    parameter int unsigned WALL_W    = WALL_W_D,
    parameter int unsigned GAP       = GAP_D,
    parameter int unsigned MIN_TOP   = MIN_TOP_D,
    parameter int unsigned MAX_TOP   = MAX_TOP_D,
    parameter int unsigned BIRD_X    = BIRD_X_D
) (
    input  logic           clk,
    input  logic           resetn,
    wall_scroller_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_WALLS);
    localparam int unsigned CNT_W = $clog2(SPACING);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_WALLS-1:0] valid_q, valid_d;
    logic [7:0]           x_q   [NUM_WALLS];
    logic [7:0]           x_d   [NUM_WALLS];
    logic [6:0]           top_q [NUM_WALLS];
    logic [6:0]           top_d [NUM_WALLS];
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [7:0]           score_q, score_d;
    logic                 collide_q, collide_d;

    logic                 u_valid, u_passed, u_hit;
    logic [7:0]           u_x;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;

    wall_slot_update #(
        .SPEED  (SPEED),
        .WALL_W (WALL_W),
        .GAP    (GAP),
        .BIRD_X (BIRD_X)
    ) u_slot (
        .valid_i  (valid_q[idx_q]),
        .x_i      (x_q[idx_q]),
        .top_i    (top_q[idx_q]),
        .bird_y_i (bus.bird_y),
        .valid_o  (u_valid),
        .x_o      (u_x),
        .passed_o (u_passed),
        .hit_o    (u_hit)
    );

    // Lowest-index free slot; slots retired during SCROLL are already free here.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_WALLS; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        valid_d        = valid_q;
        x_d            = x_q;
        top_d          = top_q;
        cnt_d          = cnt_q;
        score_d        = score_q;
        collide_d      = collide_q;
        bus.busy       = (state_q != ST_IDLE);
        bus.frame_done = 1'b0;
        bus.height_ack = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.frame_tick && bus.enable) begin
                    state_d = ST_SCROLL;
                    idx_d   = '0;
                end
            end
            ST_SCROLL: begin
                valid_d[idx_q] = u_valid;
                x_d[idx_q]     = u_x;
                if (u_passed && (score_q != 8'hFF)) score_d = score_q + 8'd1;
                if (u_hit) collide_d = 1'b1;
                if (idx_q == IDX_W'(NUM_WALLS - 1)) state_d = ST_SPAWN;
                else idx_d = idx_q + 1'b1;
            end
            ST_SPAWN: begin
                bus.frame_done = 1'b1;
                state_d        = ST_IDLE;
                // With every slot occupied the counter parks at its terminal value.
                if (cnt_q == CNT_W'(SPACING - 1)) begin
                    if (free_found) begin
                        valid_d[free_idx] = 1'b1;
                        x_d[free_idx]     = 8'(SCREEN_W - 1);
                        top_d[free_idx]   = clamp_top(bus.height_in, MIN_TOP, MAX_TOP);
                        bus.height_ack    = 1'b1;
                        cnt_d             = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            valid_q   <= '0;
            x_q       <= '{default: '0};
            top_q     <= '{default: '0};
            cnt_q     <= '0;
            score_q   <= '0;
            collide_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            x_q       <= x_d;
            top_q     <= top_d;
            cnt_q     <= cnt_d;
            score_q   <= score_d;
            collide_q <= collide_d;
        end
    end

    assign bus.rd_valid = valid_q[bus.rd_idx];
    assign bus.rd_x     = x_q[bus.rd_idx];
    assign bus.rd_top   = top_q[bus.rd_idx];
    assign bus.score    = score_q;
    assign bus.collide  = collide_q;

endmodule
